// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline boundary registers: result-mux
// encodings, default widths, the skid-buffer occupancy states and the
// EX/MEM payload width used when packing stage signals into one vector.
package riscv_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    SKB_EMPTY = 2'd0,
    SKB_ONE   = 2'd1,
    SKB_FULL  = 2'd2
  } skid_state_e;

  // RegWrite + MemWrite + ResultSrc(2) + ALUResult + WriteData + PCPlus4 + Rd
  function automatic int exmem_w(input int xlen, input int rw);
    return 4 + 3 * xlen + rw;
  endfunction

  localparam int EXMEM_W = exmem_w(XLEN_DEF, RW_DEF);

endpackage

// File: rtl/ex_mem_stage_if.sv
// One side of the EX/MEM boundary: a valid/ready beat plus its payload.
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high; the master keeps valid and the payload stable until that edge,
// and valid never waits on ready.
interface ex_mem_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5
);
  logic            valid;
  logic            ready;
  logic            RegWrite;
  logic            MemWrite;
  logic [1:0]      ResultSrc;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] WriteData;
  logic [XLEN-1:0] PCPlus4;
  logic [RW-1:0]   Rd;

  modport master (
    output valid, RegWrite, MemWrite, ResultSrc, ALUResult, WriteData, PCPlus4, Rd,
    input  ready
  );

  modport slave (
    input  valid, RegWrite, MemWrite, ResultSrc, ALUResult, WriteData, PCPlus4, Rd,
    output ready
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic WIDTH-wide valid/ready buffer with synchronous flush. SKID=1 gives
// a 2-entry skid buffer whose in_ready comes only from registered state;
// SKID=0 gives a single register with a combinational ready pass-through.
module pipe_skid_buf
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output skid_state_e      state_dbg
);

  skid_state_e      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state != SKB_EMPTY);
  assign out_data  = main_q;
  assign state_dbg = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = reset_n & (state != SKB_FULL);
    end else begin : g_single
      assign in_ready = reset_n & (~out_valid | out_ready);
    end
  endgenerate

  // Occupancy FSM: main_q is always the oldest beat, skid_q the second one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= SKB_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= SKB_EMPTY;
    end else begin
      case (state)
        SKB_EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= SKB_ONE;
          end
        end
        SKB_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Only reachable with SKID=1; the single-register ready forces out_fire.
            skid_q <= in_data;
            state  <= SKB_FULL;
          end else if (out_fire) begin
            state <= SKB_EMPTY;
          end
        end
        SKB_FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= SKB_ONE;
          end
        end
        default: state <= SKB_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: packs the EX control/data into a skid buffer,
// gates write-enables with out_valid so bubbles never write, and exposes a
// forwarding tap for the hazard unit.
module ex_mem_stage
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = RW_DEF,
  parameter int SKID = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  ex_mem_stage_if.slave  ex,
  ex_mem_stage_if.master mem,
  output logic           fwd_valid,
  output logic [RW-1:0]  fwd_rd,
  output skid_state_e    state_dbg
);

  localparam int PW = exmem_w(XLEN, RW);

  logic [PW-1:0]   in_data;
  logic [PW-1:0]   out_data;
  logic            out_valid;
  logic            rw_q;
  logic            mw_q;
  logic [1:0]      rs_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] wd_q;
  logic [XLEN-1:0] pc4_q;
  logic [RW-1:0]   rd_q;

  assign in_data = {ex.RegWrite, ex.MemWrite, ex.ResultSrc, ex.ALUResult,
                    ex.WriteData, ex.PCPlus4, ex.Rd};

  pipe_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (ex.valid),
    .in_ready  (ex.ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (mem.ready),
    .out_data  (out_data),
    .state_dbg (state_dbg)
  );

  assign {rw_q, mw_q, rs_q, alu_q, wd_q, pc4_q, rd_q} = out_data;

  // Write-enables are gated so a bubble or stale flushed payload never writes.
  assign mem.valid     = out_valid;
  assign mem.RegWrite  = out_valid & rw_q;
  assign mem.MemWrite  = out_valid & mw_q;
  assign mem.ResultSrc = rs_q;
  assign mem.ALUResult = alu_q;
  assign mem.WriteData = wd_q;
  assign mem.PCPlus4   = pc4_q;
  assign mem.Rd        = rd_q;

  // x0 is hard-wired zero, so it is never a forwarding source.
  assign fwd_valid = out_valid & rw_q & (rd_q != '0);
  assign fwd_rd    = fwd_valid ? rd_q : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: one SKID=1 and one SKID=0 instance share stimulus,
// with sel choosing which one is active and observed.
module tb_ex_mem_stage;
  import riscv_pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int W    = exmem_w(XLEN, RW);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, flush, in_valid, out_ready, sel, mon_en;
  logic            RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [RW-1:0]   RdE;

  ex_mem_stage_if #(.XLEN(XLEN), .RW(RW)) ex1 ();
  ex_mem_stage_if #(.XLEN(XLEN), .RW(RW)) mem1 ();
  ex_mem_stage_if #(.XLEN(XLEN), .RW(RW)) ex0 ();
  ex_mem_stage_if #(.XLEN(XLEN), .RW(RW)) mem0 ();

  logic          fwd_valid1, fwd_valid0;
  logic [RW-1:0] fwd_rd1, fwd_rd0;
  skid_state_e   st1, st0;

  assign ex1.valid = in_valid & sel;
  assign ex1.RegWrite = RegWriteE;   assign ex1.MemWrite = MemWriteE;
  assign ex1.ResultSrc = ResultSrcE; assign ex1.ALUResult = ALUResultE;
  assign ex1.WriteData = WriteDataE; assign ex1.PCPlus4 = PCPlus4E;
  assign ex1.Rd = RdE;
  assign ex0.valid = in_valid & ~sel;
  assign ex0.RegWrite = RegWriteE;   assign ex0.MemWrite = MemWriteE;
  assign ex0.ResultSrc = ResultSrcE; assign ex0.ALUResult = ALUResultE;
  assign ex0.WriteData = WriteDataE; assign ex0.PCPlus4 = PCPlus4E;
  assign ex0.Rd = RdE;
  assign mem1.ready = out_ready;
  assign mem0.ready = out_ready;

  ex_mem_stage #(.XLEN(XLEN), .RW(RW), .SKID(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ex(ex1), .mem(mem1),
    .fwd_valid(fwd_valid1), .fwd_rd(fwd_rd1), .state_dbg(st1));

  ex_mem_stage #(.XLEN(XLEN), .RW(RW), .SKID(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ex(ex0), .mem(mem0),
    .fwd_valid(fwd_valid0), .fwd_rd(fwd_rd0), .state_dbg(st0));

  // Observed view of the selected instance
  logic            obs_in_ready, obs_out_valid, obs_rw, obs_mw, obs_fwd_valid;
  logic [1:0]      obs_rs;
  logic [XLEN-1:0] obs_alu, obs_wd, obs_pc4;
  logic [RW-1:0]   obs_rd, obs_fwd_rd;
  skid_state_e     obs_state;
  logic [W-1:0]    obs_payload, exp_in;

  always_comb begin
    obs_in_ready  = sel ? ex1.ready      : ex0.ready;
    obs_out_valid = sel ? mem1.valid     : mem0.valid;
    obs_rw        = sel ? mem1.RegWrite  : mem0.RegWrite;
    obs_mw        = sel ? mem1.MemWrite  : mem0.MemWrite;
    obs_rs        = sel ? mem1.ResultSrc : mem0.ResultSrc;
    obs_alu       = sel ? mem1.ALUResult : mem0.ALUResult;
    obs_wd        = sel ? mem1.WriteData : mem0.WriteData;
    obs_pc4       = sel ? mem1.PCPlus4   : mem0.PCPlus4;
    obs_rd        = sel ? mem1.Rd        : mem0.Rd;
    obs_fwd_valid = sel ? fwd_valid1     : fwd_valid0;
    obs_fwd_rd    = sel ? fwd_rd1        : fwd_rd0;
    obs_state     = sel ? st1            : st0;
  end

  assign obs_payload = {obs_rw, obs_mw, obs_rs, obs_alu, obs_wd, obs_pc4, obs_rd};
  assign exp_in      = {RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, PCPlus4E, RdE};

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [XLEN-1:0] alu, input logic [RW-1:0] rd, input logic rw);
    RegWriteE  = rw;
    MemWriteE  = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 2));
    ALUResultE = alu;
    WriteDataE = $urandom;
    PCPlus4E   = $urandom;
    RdE        = rd;
  endtask

  // Stream n beats through the selected instance with a per-cycle out_ready pattern.
  task automatic run_traffic(input string tag, input int n, input logic [XLEN-1:0] base,
                             input logic [31:0] pat, input bit check_rate);
    int  next = 0;
    int  cycles = 0;
    bit  fire;
    bit  done = 0;
    for (int c = 0; c < 400; c++) begin
      if (next == n && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      out_ready = pat[c % 32];
      if (next < n) begin
        if (!in_valid) begin
          drive_beat(base + XLEN'(next), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
          in_valid = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      fire = in_valid & obs_in_ready;
      step();
      cycles++;
      if (fire) begin
        next++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_done"}, 128'(done), 128'd1);
    if (check_rate) chk({tag, "_cycles"}, 128'(cycles), 128'(n + 1));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        chk("out_valid", 128'(obs_out_valid), 128'(exp_q.size() != 0));
        chk("in_ready", 128'(obs_in_ready),
            sel ? 128'(exp_q.size() < 2) : 128'((exp_q.size() == 0) || out_ready));
        if (obs_out_valid && exp_q.size() != 0) begin
          chk("payload", 128'(obs_payload), 128'(exp_q[0]));
          chk("fwd_valid", 128'(obs_fwd_valid),
              128'(exp_q[0][W-1] && (exp_q[0][RW-1:0] != '0)));
          chk("fwd_rd", 128'(obs_fwd_rd),
              (exp_q[0][W-1] && (exp_q[0][RW-1:0] != '0)) ? 128'(exp_q[0][RW-1:0]) : 128'd0);
        end else begin
          chk("bubble", 128'({obs_rw, obs_mw, obs_fwd_valid, obs_fwd_rd}), 128'd0);
        end
        if (flush) begin
          exp_q.delete();
        end else begin
          if (obs_out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
          if (in_valid && obs_in_ready) exp_q.push_back(exp_in);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1; sel = 1'b1; mon_en = 1'b0;
    drive_beat(32'h99, 5'd3, 1'b1);
    in_valid = 1'b1;

    // Reset held 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outs", 128'({obs_out_valid, obs_payload, obs_fwd_valid, obs_fwd_rd}), 128'd0);
      chk("rst_in_ready", 128'(obs_in_ready), 128'd0);
      chk("rst_state", 128'(obs_state), 128'(SKB_EMPTY));
    end
    reset_n = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_in_ready", 128'(obs_in_ready), 128'd1);
    mon_en = 1'b1;

    // Streaming, 1-cycle latency, no gaps
    for (int i = 0; i < 8; i++) begin
      drive_beat(32'h10 + i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      in_valid = 1'b1;
      step();
      chk("stream_valid", 128'(obs_out_valid), 128'd1);
      chk("stream_alu", 128'(obs_alu), 128'(32'h10 + i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 128'(obs_out_valid), 128'd0);

    // Stall from beat 2: beat 3 lands in skid, outputs hold beat 2
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h20 + i, 5'd4, 1'b1);
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b0;
    drive_beat(32'h23, 5'd5, 1'b1);
    step();
    chk("stall_in_ready", 128'(obs_in_ready), 128'd0);
    chk("stall_state", 128'(obs_state), 128'(SKB_FULL));
    chk("stall_hold", 128'(obs_alu), 128'h22);
    drive_beat(32'h24, 5'd6, 1'b1);
    step();
    step();
    chk("stall_hold2", 128'(obs_alu), 128'h22);
    out_ready = 1'b1;
    step();
    chk("release_b3", 128'(obs_alu), 128'h23);
    step();
    chk("release_b4", 128'(obs_alu), 128'h24);
    in_valid = 1'b0;
    step();
    chk("release_empty", 128'(obs_out_valid), 128'd0);

    // Flush while FULL with an incoming beat
    out_ready = 1'b0;
    drive_beat(32'h30, 5'd8, 1'b1); in_valid = 1'b1; step();
    drive_beat(32'h31, 5'd9, 1'b1); step();
    drive_beat(32'h32, 5'd7, 1'b1); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 128'(obs_out_valid), 128'd0);
    chk("flush_we", 128'({obs_rw, obs_mw, obs_fwd_valid}), 128'd0);
    chk("flush_in_ready", 128'(obs_in_ready), 128'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Flush in ONE together with an accepted beat
    out_ready = 1'b0;
    drive_beat(32'h33, 5'd10, 1'b1); in_valid = 1'b1; step();
    drive_beat(32'h34, 5'd7, 1'b1); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 128'(obs_out_valid), 128'd0);
    chk("flush1_in_ready", 128'(obs_in_ready), 128'd1);
    out_ready = 1'b1;
    step();

    // Forwarding tap
    out_ready = 1'b0;
    drive_beat(32'h40, 5'd0, 1'b1); in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("fwd_rd0_valid", 128'(obs_fwd_valid), 128'd0);
    chk("fwd_rd0_rd", 128'(obs_fwd_rd), 128'd0);
    chk("fwd_rd0_rw", 128'(obs_rw), 128'd1);
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    drive_beat(32'h41, 5'd12, 1'b1); in_valid = 1'b1; step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fwd12_valid", 128'(obs_fwd_valid), 128'd1);
      chk("fwd12_rd", 128'(obs_fwd_rd), 128'd12);
      step();
    end
    out_ready = 1'b1; step();

    // Reset asserted mid-stall
    out_ready = 1'b0;
    drive_beat(32'h50, 5'd1, 1'b1); in_valid = 1'b1; step();
    drive_beat(32'h51, 5'd2, 1'b1); step();
    in_valid = 1'b0;
    chk("pre_rst_state", 128'(obs_state), 128'(SKB_FULL));
    reset_n = 1'b0; step();
    chk("midrst_valid", 128'(obs_out_valid), 128'd0);
    chk("midrst_state", 128'(obs_state), 128'(SKB_EMPTY));
    chk("midrst_in_ready", 128'(obs_in_ready), 128'd0);
    reset_n = 1'b1; out_ready = 1'b1; step();
    chk("midrst_rel", 128'(obs_in_ready), 128'd1);

    // Randomised backpressure on the skid build
    run_traffic("skid_rand", 16, 32'h100, $urandom, 1'b0);

    // Single-register build: streaming and stalls
    sel = 1'b0;
    step();
    run_traffic("single_stream", 8, 32'h10, 32'hFFFF_FFFF, 1'b1);
    run_traffic("single_stall", 10, 32'h20, 32'b1100_0111_0001_1011_1000_0111_0011_0011, 1'b0);
    run_traffic("single_rand", 16, 32'h200, $urandom, 1'b0);

    chk("final_queue", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX→MEM pipeline boundary for the RV32 core. It replaces the plain always-enabled EX/MEM register with a valid/ready stage and adds:
- a 2-entry skid buffer, so a MEM-side stall (data-memory wait) backpressures EX without a combinational ready path;
- a synchronous flush for branch/exception kill;
- bubble gating of write-enables;
- a forwarding tap for the hazard unit.

It sits between the ALU/EX stage and the data-memory/MEM stage.

## Interface
Parameters:
- XLEN, 32, width of ALUResult, WriteData, PCPlus4.
- RW, 5, register-index width (Rd).
- SKID, 1, 1 = 2-entry skid buffer; 0 = single register with ready = !valid || out_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset (sampled on clk rising edge).
- flush  in  1  kill all held entries and the incoming beat this cycle.
- in_valid  in  1  EX beat present.
- in_ready  out  1  stage can accept; registered, never depends combinationally on out_ready when SKID=1.
- RegWriteE, MemWriteE  in  1 each  control.
- ResultSrcE  in  2  result-mux select.
- ALUResultE, WriteDataE, PCPlus4E  in  XLEN each.
- RdE  in  RW.
- out_valid  out  1  MEM beat present.
- out_ready  in  1  MEM consumes beat.
- RegWriteM, MemWriteM  out  1 each  gated with out_valid.
- ResultSrcM  out  2.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each.
- RdM  out  RW.
- fwd_valid  out  1  out_valid & RegWriteM & (RdM != 0).
- fwd_rd  out  RW  RdM when fwd_valid, else 0.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Occupancy FSM, SKID=1:
  - EMPTY: in_fire → ONE.
  - ONE: in_fire & !out_fire → FULL; out_fire & !in_fire → EMPTY; both → ONE, main entry replaced by the new beat.
  - FULL: out_fire → ONE, skid entry moves to main. in_ready = 0, so no in_fire.
- Ordering strictly FIFO. Outputs always present the main (oldest) entry.
- in_ready = (state != FULL) & reset_n.
- flush (highest priority after reset): next state EMPTY, both entries invalidated, the incoming beat is dropped even if in_fire. Payload registers may hold stale data, but RegWriteM, MemWriteM and fwd_valid must read 0.
- Bubble: whenever out_valid = 0, RegWriteM = MemWriteM = 0 and fwd_valid = 0. Other payload is don't-care but must be stable while out_valid & !out_ready (hold rule).
- Rd = 0 never asserts fwd_valid.

## Timing
- Reset (reset_n = 0 at a clk edge): state EMPTY, out_valid = 0, all payload outputs 0, fwd_rd = 0. in_ready = 0 while reset_n is low; 1 on the first cycle after release.
- Latency: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1). Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: if out_ready drops, at most one further beat is accepted (into skid). in_ready falls one cycle later.
- Simultaneous flush & in_valid: beat lost, in_ready = 1 the next cycle.
- Simultaneous flush & reset: reset wins; result is identical.
- Reset asserted mid-stall (FULL): both entries discarded, no out_fire.
- SKID=0: in_ready = !out_valid | out_ready (combinational path allowed). Otherwise identical rules.

## Structure
- Shared package riscv_pipe_pkg: ResultSrc encodings (RES_ALU = 0, RES_MEM = 1, RES_PC4 = 2), default XLEN/RW constants, and the EX/MEM payload bit-width used for packing.
- One sub-module is natural: pipe_skid_buf (generic WIDTH-wide 2-entry valid/ready buffer with flush). ex_mem_stage packs the payload into it and applies bubble gating and the forwarding tap on its output.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0, all outputs 0, in_ready = 0. After release, in_ready = 1.
- Streaming: 8 beats ALUResultE = 0x10..0x17, out_ready = 1 → identical sequence out, 1-cycle latency, no gaps.
- Stall: out_ready = 0 from beat 2 → beat 3 lands in skid, in_ready = 0 on the following cycle. Outputs hold beat 2 unchanged. Release → beats 2, 3, 4 in order, none lost or duplicated.
- Flush while FULL with in_valid = 1 (beat RdE = 7, RegWriteE = 1) → next cycle out_valid = 0, RegWriteM = 0, fwd_valid = 0. Neither the held beats nor the incoming beat ever appears.
- Forwarding: beat RdE = 0, RegWriteE = 1 → fwd_valid = 0. Beat RdE = 12, RegWriteE = 1 → fwd_valid = 1, fwd_rd = 12 while the beat is held.
- SKID=0 build: repeat the streaming and stall scenarios → same data order, and in_ready tracks out_ready combinationally when out_valid = 1.
